// File: rtl/aes_pkg.sv
// Shared definitions for the AES result path.
// Contents:
//   AES_BLK_W / AES_WORD_W / AES_WORDS_PER_BLK : block and bus geometry
//   AES_IDX_W / AES_LAST_IDX                   : word index width and final index
//   ser_state_t                                : serializer FSM states
package aes_pkg;

    localparam int AES_BLK_W         = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;
    localparam int AES_IDX_W         = $clog2(AES_WORDS_PER_BLK);

    localparam logic [AES_IDX_W-1:0] AES_LAST_IDX = AES_IDX_W'(AES_WORDS_PER_BLK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// Small synchronous FIFO holding whole AES result blocks.
// Pointers are one bit wider than the address so that full and empty are told
// apart by the extra MSB; both pointers wrap naturally.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push/wdata : write wdata at the tail (ignored when full unless popping)
//   pop/rdata  : rdata always shows the head; pop advances it
//   full/empty : occupancy flags
module aes_blk_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // When full, a simultaneous pop frees the head slot, which is the same
    // slot the write lands in; the read below still sees the old contents.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/aes_result_serializer.sv
// Captures each 128-bit AES result on the rising edge of AES_data_out_valid,
// buffers it in a small FIFO and streams it as four 32-bit words, most
// significant first, over a valid/ready handshake.
// Optional feature macro: AES_SER_OVF_CNT_EN adds an 8-bit saturating count of
// dropped blocks (ser_ovf_cnt) and derives ser_ovf from it.
// Ports:
//   AES_clk, AES_rst_n            : clock, asynchronous active-low reset
//   AES_data_out_valid/_out       : result strobe and data from AES_top
//   ser_word_out/valid/ready/last : word stream to the consumer
//   ser_busy                      : FIFO non-empty or a block in flight
//   ser_ovf                       : sticky, a result was dropped on a full FIFO
//   ser_ovf_cnt                   : (AES_SER_OVF_CNT_EN only) dropped-block count
module aes_result_serializer
    import aes_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  AES_clk,
    input  logic                  AES_rst_n,
    input  logic                  AES_data_out_valid,
    input  logic [AES_BLK_W-1:0]  AES_data_out,
    output logic [AES_WORD_W-1:0] ser_word_out,
    output logic                  ser_word_valid,
    input  logic                  ser_word_ready,
    output logic                  ser_word_last,
    output logic                  ser_busy,
    output logic                  ser_ovf
`ifdef AES_SER_OVF_CNT_EN
    ,
    output logic [7:0]            ser_ovf_cnt
`endif
);

    logic                 vld_d;
    logic                 capture;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    logic                 hs;
    logic                 load;
    logic [AES_BLK_W-1:0] fifo_rdata;
    logic [AES_BLK_W-1:0] shreg;
    logic [AES_IDX_W-1:0] idx;
    ser_state_t           state;
    ser_state_t           next_state;

    // Only a rising edge of valid captures, so a held-high strobe counts once.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) vld_d <= 1'b0;
        else            vld_d <= AES_data_out_valid;
    end

    assign capture   = AES_data_out_valid & ~vld_d;
    assign fifo_push = capture & (~fifo_full | fifo_pop);
    assign drop      = capture & fifo_full & ~fifo_pop;

    aes_blk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AES_BLK_W)
    ) u_fifo (
        .clk   (AES_clk),
        .rst_n (AES_rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (AES_data_out),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hs = (state == SEND) & ser_word_ready;

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    // Reloading on the final handshake keeps consecutive blocks bubble-free.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    fifo_pop   = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (hs && (idx == AES_LAST_IDX)) begin
                    if (!fifo_empty) begin
                        load     = 1'b1;
                        fifo_pop = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= fifo_rdata;
            idx   <= '0;
        end else if (hs) begin
            shreg <= {shreg[AES_BLK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
            idx   <= idx + 1'b1;
        end
    end

    assign ser_word_out   = shreg[AES_BLK_W-1 -: AES_WORD_W];
    assign ser_word_valid = (state == SEND);
    assign ser_word_last  = (state == SEND) && (idx == AES_LAST_IDX);
    assign ser_busy       = (state == SEND) | ~fifo_empty;

`ifdef AES_SER_OVF_CNT_EN
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n)                     ser_ovf_cnt <= 8'd0;
        else if (drop && ser_ovf_cnt != 8'hFF) ser_ovf_cnt <= ser_ovf_cnt + 8'd1;
    end

    assign ser_ovf = (ser_ovf_cnt != 8'd0);
`else
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) ser_ovf <= 1'b0;
        else if (drop)  ser_ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_aes_result_serializer.sv
// Testbench for aes_result_serializer: randomized and directed stimulus,
// behavioural block-level reference model, word scoreboard.
module tb_aes_result_serializer;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] w;
        logic        last;
    } wexp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din_valid = 1'b0;
    logic [127:0] din = '0;
    logic         ready = 1'b0;
    logic [31:0]  word;
    logic         word_valid;
    logic         word_last;
    logic         busy;
    logic         ovf;
`ifdef AES_SER_OVF_CNT_EN
    logic [7:0]   ovf_cnt;
`endif

    aes_result_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_data_out_valid (din_valid),
        .AES_data_out       (din),
        .ser_word_out       (word),
        .ser_word_valid     (word_valid),
        .ser_word_ready     (ready),
        .ser_word_last      (word_last),
        .ser_busy           (busy),
        .ser_ovf            (ovf)
`ifdef AES_SER_OVF_CNT_EN
        ,
        .ser_ovf_cnt        (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: blocks waiting in the buffer, words left in the block
    // being sent, and every word still expected on the bus in order.
    logic [127:0] fq[$];
    wexp_t        eq[$];
    int           words_left = 0;
    bit           m_vld_d = 0;
    bit           m_ovf = 0;
    int           m_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Inputs change 2 time units after a rising edge; at the falling edge the
    // outputs reflect the last edge and the inputs are those the next edge sees.
    always @(negedge clk) begin
        bit hs, pop, full, rise;
        if (!rst_n) begin
            fq.delete();
            eq.delete();
            words_left = 0;
            m_vld_d    = 0;
            m_ovf      = 0;
            m_cnt      = 0;
        end
        chk("valid", 32'(word_valid), 32'(words_left > 0));
        chk("busy", 32'(busy), 32'((words_left > 0) || (fq.size() > 0)));
        chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef AES_SER_OVF_CNT_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
`endif
        if (!rst_n) begin
            chk("word_rst", word, 32'd0);
            chk("last_rst", 32'(word_last), 32'd0);
        end else begin
            if (word_valid) begin
                if (eq.size() == 0) begin
                    chk("spurious_word", 32'(word_valid), 32'd0);
                end else begin
                    chk("word", word, eq[0].w);
                    chk("last", 32'(word_last), 32'(eq[0].last));
                end
            end
            // Predict the coming edge.
            hs   = (words_left > 0) && ready;
            full = (fq.size() == DEPTH);
            rise = din_valid && !m_vld_d;
            pop  = (fq.size() > 0) && ((words_left == 0) || (words_left == 1 && hs));
            if (hs && eq.size() > 0) void'(eq.pop_front());
            if (pop) begin
                void'(fq.pop_front());
                words_left = 4;
            end else if (hs) begin
                words_left--;
            end
            if (rise) begin
                if (full && !pop) begin
                    m_ovf = 1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    fq.push_back(din);
                    for (int k = 0; k < 4; k++) begin
                        wexp_t e;
                        e.w    = din[127 - 32*k -: 32];
                        e.last = (k == 3);
                        eq.push_back(e);
                    end
                end
            end
            m_vld_d = din_valid;
        end
    end

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(logic [127:0] d);
        din       = d;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        // Reset state
        step(3);
        rst_n = 1'b1;
        step(2);

        // Single block, ready high
        ready = 1'b1;
        pulse(128'h00112233_44556677_8899aabb_ccddeeff);
        step(8);

        // Held valid for 51 cycles gives one block
        din       = rnd128();
        din_valid = 1'b1;
        step(51);
        din_valid = 1'b0;
        step(8);

        // Backpressure during word 2
        din       = rnd128();
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step(2);
        ready = 1'b0;
        step(5);
        ready = 1'b1;
        step(8);

        // Overflow: ready low, more rises than the serializer plus FIFO can hold
        ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(rnd128());
        chk("ovf_set", 32'(ovf), 32'd1);
        step(3);
        ready = 1'b1;
        step(20);

        // Back-to-back: two blocks buffered, then ready released
        ready = 1'b0;
        pulse(rnd128());
        pulse(rnd128());
        ready = 1'b1;
        step(14);

        // Reset mid-block after word 1
        pulse(rnd128());
        step(1);
        rst_n = 1'b0;
        #1;
        chk("rst_now_valid", 32'(word_valid), 32'd0);
        chk("rst_now_busy", 32'(busy), 32'd0);
        chk("rst_now_ovf", 32'(ovf), 32'd0);
        chk("rst_now_word", word, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(8);

        // Valid already high at reset release captures at the first edge
        rst_n     = 1'b0;
        din       = rnd128();
        din_valid = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(3);
        din_valid = 1'b0;
        step(8);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (!din_valid && ($urandom_range(0, 3) == 0)) begin
                din       = rnd128();
                din_valid = 1'b1;
            end else if (din_valid && ($urandom_range(0, 1) == 0)) begin
                din_valid = 1'b0;
            end
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        din_valid = 1'b0;
        ready     = 1'b1;
        step(40);
        chk("drained", 32'(eq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
